// File: rtl/fmps_test_pkg.sv
// Shared constants and types for the FMPS test link (writer and reader sides).
// Provides magic values, index width, status codes and the receive-state encoding.
package fmps_test_pkg;

    localparam logic [15:0] HEADER_MAGIC     = 16'hB6CF;
    localparam logic [15:0] DATA_MAGIC       = 16'hCACA;
    localparam int          MAX_FMPSS        = 32;
    localparam int          FMPS_INDEX_WIDTH = $clog2(MAX_FMPSS);
    localparam int          COUNT_WIDTH      = 16;

    localparam logic [1:0]  CODE_OK    = 2'd0;
    localparam logic [1:0]  CODE_HDR   = 2'd1;
    localparam logic [1:0]  CODE_DATA  = 2'd2;
    localparam logic [1:0]  CODE_FRAME = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_HEADER = 2'd1,
        S_DATA   = 2'd2,
        S_DRAIN  = 2'd3
    } rx_state_t;

    // Writer-side word builders so both ends agree on the packet layout.
    function automatic logic [31:0] make_header(input logic [FMPS_INDEX_WIDTH-1:0] idx);
        return {HEADER_MAGIC, 1'b1, idx, 10'd0};
    endfunction

    function automatic logic [31:0] make_data(input logic [FMPS_INDEX_WIDTH-1:0] cnt,
                                              input logic [7:0] fa_cycle);
        return {3'd0, cnt, DATA_MAGIC, fa_cycle};
    endfunction

endpackage

// File: rtl/fmps_test_field_check.sv
// Combinational field comparison for one FMPS test word (header or data).
// Framing (tlast placement) is judged before field content.
module fmps_test_field_check
    import fmps_test_pkg::*;
(
    input  logic [31:0]                 i_word,
    input  logic                        i_tlast,
    input  logic                        i_is_data,
    input  logic [FMPS_INDEX_WIDTH-1:0] i_exp_index,
    input  logic [FMPS_INDEX_WIDTH-1:0] i_exp_data_cnt,
    input  logic [7:0]                  i_fa_cycle,
    output logic                        o_ok,
    output logic [1:0]                  o_code
);

    logic w_hdr_fields_ok;
    logic w_data_fields_ok;

    assign w_hdr_fields_ok  = (i_word[31:16] == HEADER_MAGIC) &&
                              i_word[15] &&
                              (i_word[14:10] == i_exp_index) &&
                              (i_word[9:0] == 10'd0);

    assign w_data_fields_ok = (i_word[31:29] == 3'd0) &&
                              (i_word[28:24] == i_exp_data_cnt) &&
                              (i_word[23:8] == DATA_MAGIC) &&
                              (i_word[7:0] == i_fa_cycle);

    always_comb begin
        o_code = CODE_OK;
        if (i_is_data) begin
            if (!i_tlast)               o_code = CODE_FRAME;
            else if (!w_data_fields_ok) o_code = CODE_DATA;
        end else begin
            if (i_tlast)                o_code = CODE_FRAME;
            else if (!w_hdr_fields_ok)  o_code = CODE_HDR;
        end
    end

    assign o_ok = (o_code == CODE_OK);

endmodule

// File: rtl/read_fmps_test_link.sv
// Receive-side checker for the FMPS test link: validates header/data packets from the
// Aurora RX stream and reports per-packet status plus saturating good/bad counters.
module read_fmps_test_link
    import fmps_test_pkg::*;
(
    input  logic                        auroraUserClk,
    input  logic                        auroraUserRst_n,
    input  logic                        auroraFAstrobe,
    input  logic                        auroraChannelUp,
    input  logic [FMPS_INDEX_WIDTH-1:0] baseFmpsIndex,
    input  logic [31:0]                 FMPS_TEST_AXI_STREAM_RX_tdata,
    input  logic                        FMPS_TEST_AXI_STREAM_RX_tvalid,
    input  logic                        FMPS_TEST_AXI_STREAM_RX_tlast,
    output logic                        FMPS_TEST_AXI_STREAM_RX_tready,
    output logic                        TESTstatusStrobe,
    output logic [1:0]                  TESTstatusCode,
    output logic [COUNT_WIDTH-1:0]      packetCount,
    output logic [COUNT_WIDTH-1:0]      errorCount,
    output logic [31:0]                 lastHeader,
    output logic [1:0]                  dbgRxState
);

    localparam logic [COUNT_WIDTH-1:0] CNT_ONE = COUNT_WIDTH'(1);
    localparam logic [COUNT_WIDTH-1:0] CNT_MAX = '1;

    rx_state_t                   r_state;
    rx_state_t                   w_state_nxt;
    logic [FMPS_INDEX_WIDTH-1:0] r_exp_index;
    logic [FMPS_INDEX_WIDTH-1:0] r_exp_data_cnt;
    logic [7:0]                  r_fa_cycle;
    logic                        r_strobe;
    logic [1:0]                  r_code;
    logic [COUNT_WIDTH-1:0]      r_pkt_cnt;
    logic [COUNT_WIDTH-1:0]      r_err_cnt;
    logic [31:0]                 r_last_header;
    logic                        r_chan_up_d;

    logic       w_beat;
    logic       w_chan_fall;
    logic       w_chk_ok;
    logic [1:0] w_chk_code;
    logic       w_emit;
    logic [1:0] w_emit_code;
    logic       w_advance;
    logic       w_latch_hdr;

    // Handshake: a beat is tvalid && tready; tready is high in every state but S_IDLE
    // and does not depend on tvalid, so the upstream source never stalls mid-session.
    assign FMPS_TEST_AXI_STREAM_RX_tready = (r_state != S_IDLE);
    assign w_beat      = FMPS_TEST_AXI_STREAM_RX_tvalid && FMPS_TEST_AXI_STREAM_RX_tready;
    assign w_chan_fall = r_chan_up_d && !auroraChannelUp;

    fmps_test_field_check u_field_check (
        .i_word         (FMPS_TEST_AXI_STREAM_RX_tdata),
        .i_tlast        (FMPS_TEST_AXI_STREAM_RX_tlast),
        .i_is_data      (r_state == S_DATA),
        .i_exp_index    (r_exp_index),
        .i_exp_data_cnt (r_exp_data_cnt),
        .i_fa_cycle     (r_fa_cycle),
        .o_ok           (w_chk_ok),
        .o_code         (w_chk_code)
    );

    // Priority: session restart, then channel loss, then stream beats.
    always_comb begin
        w_state_nxt = r_state;
        w_emit      = 1'b0;
        w_emit_code = CODE_OK;
        w_advance   = 1'b0;
        w_latch_hdr = 1'b0;
        if (auroraFAstrobe) begin
            w_state_nxt = S_HEADER;
        end else if (w_chan_fall) begin
            w_state_nxt = S_IDLE;
            if (r_state == S_DATA || r_state == S_DRAIN) begin
                w_emit      = 1'b1;
                w_emit_code = CODE_FRAME;
            end
        end else if (w_beat) begin
            case (r_state)
                S_HEADER: begin
                    w_latch_hdr = 1'b1;
                    w_emit      = !w_chk_ok;
                    w_emit_code = w_chk_code;
                    if (w_chk_ok)                       w_state_nxt = S_DATA;
                    else if (w_chk_code == CODE_FRAME)  w_state_nxt = S_HEADER;
                    else                                w_state_nxt = S_DRAIN;
                end
                S_DATA: begin
                    w_emit      = 1'b1;
                    w_emit_code = w_chk_code;
                    w_advance   = 1'b1;
                    w_state_nxt = FMPS_TEST_AXI_STREAM_RX_tlast ? S_HEADER : S_DRAIN;
                end
                S_DRAIN: begin
                    if (FMPS_TEST_AXI_STREAM_RX_tlast) w_state_nxt = S_HEADER;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge auroraUserClk or negedge auroraUserRst_n) begin
        if (!auroraUserRst_n) begin
            r_state        <= S_IDLE;
            r_exp_index    <= '0;
            r_exp_data_cnt <= '0;
            r_fa_cycle     <= '0;
            r_strobe       <= 1'b0;
            r_code         <= CODE_OK;
            r_pkt_cnt      <= '0;
            r_err_cnt      <= '0;
            r_last_header  <= '0;
            r_chan_up_d    <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_chan_up_d <= auroraChannelUp;
            r_strobe    <= w_emit;
            if (w_emit) r_code <= w_emit_code;
            if (w_latch_hdr) r_last_header <= FMPS_TEST_AXI_STREAM_RX_tdata;
            if (auroraFAstrobe) begin
                r_exp_index    <= baseFmpsIndex;
                r_exp_data_cnt <= '0;
                r_fa_cycle     <= r_fa_cycle + 8'd1;
                r_pkt_cnt      <= '0;
                r_err_cnt      <= '0;
            end else begin
                if (w_advance) begin
                    r_exp_index    <= r_exp_index + FMPS_INDEX_WIDTH'(1);
                    r_exp_data_cnt <= r_exp_data_cnt + FMPS_INDEX_WIDTH'(1);
                end
                if (w_emit) begin
                    if (w_emit_code == CODE_OK) begin
                        if (r_pkt_cnt != CNT_MAX) r_pkt_cnt <= r_pkt_cnt + CNT_ONE;
                    end else begin
                        if (r_err_cnt != CNT_MAX) r_err_cnt <= r_err_cnt + CNT_ONE;
                    end
                end
            end
        end
    end

    assign TESTstatusStrobe = r_strobe;
    assign TESTstatusCode   = r_code;
    assign packetCount      = r_pkt_cnt;
    assign errorCount       = r_err_cnt;
    assign lastHeader       = r_last_header;
    assign dbgRxState       = r_state;

endmodule

// File: tb/tb_read_fmps_test_link.sv
// Directed bench for read_fmps_test_link: packet streams with hand-computed status,
// counter and state expectations, covering error codes, drain, channel loss and wrap.
module tb_read_fmps_test_link;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        fa;
    logic        chan_up;
    logic [4:0]  base;
    logic [31:0] tdata;
    logic        tvalid;
    logic        tlast;
    logic        tready;
    logic        strobe;
    logic [1:0]  code;
    logic [15:0] pkt_cnt;
    logic [15:0] err_cnt;
    logic [31:0] last_hdr;
    logic [1:0]  dbg;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    read_fmps_test_link dut (
        .auroraUserClk                  (clk),
        .auroraUserRst_n                (rst_n),
        .auroraFAstrobe                 (fa),
        .auroraChannelUp                (chan_up),
        .baseFmpsIndex                  (base),
        .FMPS_TEST_AXI_STREAM_RX_tdata  (tdata),
        .FMPS_TEST_AXI_STREAM_RX_tvalid (tvalid),
        .FMPS_TEST_AXI_STREAM_RX_tlast  (tlast),
        .FMPS_TEST_AXI_STREAM_RX_tready (tready),
        .TESTstatusStrobe               (strobe),
        .TESTstatusCode                 (code),
        .packetCount                    (pkt_cnt),
        .errorCount                     (err_cnt),
        .lastHeader                     (last_hdr),
        .dbgRxState                     (dbg)
    );

    function automatic logic [31:0] hdr(input logic [15:0] magic, input logic [4:0] idx);
        return {magic, 1'b1, idx, 10'd0};
    endfunction

    function automatic logic [31:0] dat(input logic [4:0] cnt, input logic [7:0] fac,
                                        input logic [15:0] magic);
        return {3'd0, cnt, magic, fac};
    endfunction

    // All tasks start and end 1 time unit after a rising edge.
    task automatic send_beat(input logic [31:0] d, input logic l);
        tdata = d; tvalid = 1'b1; tlast = l;
        @(posedge clk); #1;
        tvalid = 1'b0; tlast = 1'b0;
    endtask

    task automatic fa_pulse(input logic [4:0] b);
        fa = 1'b1; base = b;
        @(posedge clk); #1;
        fa = 1'b0;
    endtask

    task automatic idle_cycle();
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        n_tests++; if ({tready, strobe, code, dbg} !== 6'd0) begin n_fail++;
            $display("FAIL reset_ctl: tready=%b strobe=%b code=%0d state=%0d, expected all 0", tready, strobe, code, dbg); end
        n_tests++; if ({pkt_cnt, err_cnt, last_hdr} !== 64'd0) begin n_fail++;
            $display("FAIL reset_regs: pkt=%0d err=%0d hdr=%h, expected 0", pkt_cnt, err_cnt, last_hdr); end
        send_beat(hdr(16'hB6CF, 5'd0), 1'b0);
        n_tests++; if (dbg !== 2'd0 || strobe !== 1'b0 || last_hdr !== 32'd0) begin n_fail++;
            $display("FAIL idle_ignore: state=%0d strobe=%b hdr=%h, expected 0/0/0", dbg, strobe, last_hdr); end
    endtask

    task automatic test_basic();
        fa_pulse(5'd3);
        n_tests++; if (dbg !== 2'd1 || tready !== 1'b1) begin n_fail++;
            $display("FAIL fa_start: state=%0d tready=%b, expected 1/1", dbg, tready); end
        for (int i = 0; i < 4; i++) begin
            send_beat(hdr(16'hB6CF, 5'(3 + i)), 1'b0);
            n_tests++; if (strobe !== 1'b0 || dbg !== 2'd2) begin n_fail++;
                $display("FAIL basic_hdr%0d: strobe=%b state=%0d, expected 0/2", i, strobe, dbg); end
            send_beat(dat(5'(i), 8'd1, 16'hCACA), 1'b1);
            n_tests++; if (strobe !== 1'b1 || code !== 2'd0 || dbg !== 2'd1) begin n_fail++;
                $display("FAIL basic_data%0d: strobe=%b code=%0d state=%0d, expected 1/0/1", i, strobe, code, dbg); end
        end
        idle_cycle();
        n_tests++; if (strobe !== 1'b0) begin n_fail++;
            $display("FAIL basic_pulse: strobe=%b, expected 0", strobe); end
        n_tests++; if (pkt_cnt !== 16'd4 || err_cnt !== 16'd0 || last_hdr !== 32'hB6CF_9800) begin n_fail++;
            $display("FAIL basic_totals: pkt=%0d err=%0d hdr=%h, expected 4/0/b6cf9800", pkt_cnt, err_cnt, last_hdr); end
    endtask

    task automatic test_bad_header();
        send_beat(hdr(16'hB6CE, 5'd7), 1'b0);
        n_tests++; if (strobe !== 1'b1 || code !== 2'd1 || dbg !== 2'd3 || last_hdr !== 32'hB6CE_9C00) begin n_fail++;
            $display("FAIL badhdr: strobe=%b code=%0d state=%0d hdr=%h, expected 1/1/3/b6ce9c00", strobe, code, dbg, last_hdr); end
        send_beat(dat(5'd4, 8'd1, 16'hCACA), 1'b1);
        n_tests++; if (strobe !== 1'b0 || dbg !== 2'd1) begin n_fail++;
            $display("FAIL badhdr_drain: strobe=%b state=%0d, expected 0/1", strobe, dbg); end
        send_beat(hdr(16'hB6CF, 5'd7), 1'b0);
        send_beat(dat(5'd4, 8'd1, 16'hCACA), 1'b1);
        n_tests++; if (strobe !== 1'b1 || code !== 2'd0 || pkt_cnt !== 16'd5 || err_cnt !== 16'd1) begin n_fail++;
            $display("FAIL badhdr_resync: strobe=%b code=%0d pkt=%0d err=%0d, expected 1/0/5/1", strobe, code, pkt_cnt, err_cnt); end
    endtask

    task automatic test_bad_data();
        send_beat(hdr(16'hB6CF, 5'd8), 1'b0);
        send_beat(dat(5'd5, 8'd1, 16'hCACB), 1'b1);
        n_tests++; if (strobe !== 1'b1 || code !== 2'd2 || err_cnt !== 16'd2 || dbg !== 2'd1) begin n_fail++;
            $display("FAIL baddata: strobe=%b code=%0d err=%0d state=%0d, expected 1/2/2/1", strobe, code, err_cnt, dbg); end
        send_beat(hdr(16'hB6CF, 5'd9), 1'b0);
        send_beat(dat(5'd6, 8'd1, 16'hCACA), 1'b1);
        n_tests++; if (strobe !== 1'b1 || code !== 2'd0 || pkt_cnt !== 16'd6) begin n_fail++;
            $display("FAIL baddata_advance: strobe=%b code=%0d pkt=%0d, expected 1/0/6", strobe, code, pkt_cnt); end
    endtask

    task automatic test_framing();
        send_beat(hdr(16'hB6CF, 5'd10), 1'b0);
        send_beat(dat(5'd7, 8'd1, 16'hCACA), 1'b0);
        n_tests++; if (strobe !== 1'b1 || code !== 2'd3 || dbg !== 2'd3 || err_cnt !== 16'd3) begin n_fail++;
            $display("FAIL notlast: strobe=%b code=%0d state=%0d err=%0d, expected 1/3/3/3", strobe, code, dbg, err_cnt); end
        send_beat(32'h1234_5678, 1'b0);
        n_tests++; if (strobe !== 1'b0 || dbg !== 2'd3) begin n_fail++;
            $display("FAIL drain_hold: strobe=%b state=%0d, expected 0/3", strobe, dbg); end
        send_beat(32'h8765_4321, 1'b1);
        n_tests++; if (strobe !== 1'b0 || dbg !== 2'd1) begin n_fail++;
            $display("FAIL drain_exit: strobe=%b state=%0d, expected 0/1", strobe, dbg); end
        send_beat(hdr(16'hB6CF, 5'd11), 1'b0);
        send_beat(dat(5'd8, 8'd1, 16'hCACA), 1'b1);
        n_tests++; if (strobe !== 1'b1 || code !== 2'd0 || pkt_cnt !== 16'd7) begin n_fail++;
            $display("FAIL notlast_resync: strobe=%b code=%0d pkt=%0d, expected 1/0/7", strobe, code, pkt_cnt); end
        send_beat(hdr(16'hB6CF, 5'd12), 1'b1);
        n_tests++; if (strobe !== 1'b1 || code !== 2'd3 || dbg !== 2'd1 || last_hdr !== 32'hB6CF_B000 || err_cnt !== 16'd4) begin n_fail++;
            $display("FAIL hdr_tlast: strobe=%b code=%0d state=%0d hdr=%h err=%0d, expected 1/3/1/b6cfb000/4", strobe, code, dbg, last_hdr, err_cnt); end
        send_beat(hdr(16'hB6CF, 5'd12), 1'b0);
        send_beat(dat(5'd9, 8'd1, 16'hCACA), 1'b1);
        n_tests++; if (strobe !== 1'b1 || code !== 2'd0 || pkt_cnt !== 16'd8) begin n_fail++;
            $display("FAIL hdr_tlast_resync: strobe=%b code=%0d pkt=%0d, expected 1/0/8", strobe, code, pkt_cnt); end
    endtask

    task automatic test_chan_drop();
        send_beat(hdr(16'hB6CF, 5'd13), 1'b0);
        chan_up = 1'b0;
        idle_cycle();
        n_tests++; if (strobe !== 1'b1 || code !== 2'd3 || dbg !== 2'd0 || tready !== 1'b0 || err_cnt !== 16'd5) begin n_fail++;
            $display("FAIL chan_drop: strobe=%b code=%0d state=%0d tready=%b err=%0d, expected 1/3/0/0/5", strobe, code, dbg, tready, err_cnt); end
        chan_up = 1'b1;
        send_beat(dat(5'd10, 8'd1, 16'hCACA), 1'b1);
        n_tests++; if (strobe !== 1'b0 || dbg !== 2'd0 || err_cnt !== 16'd5 || pkt_cnt !== 16'd8) begin n_fail++;
            $display("FAIL chan_idle: strobe=%b state=%0d err=%0d pkt=%0d, expected 0/0/5/8", strobe, dbg, err_cnt, pkt_cnt); end
    endtask

    task automatic test_wrap();
        fa_pulse(5'd0);
        n_tests++; if (pkt_cnt !== 16'd0 || err_cnt !== 16'd0 || dbg !== 2'd1) begin n_fail++;
            $display("FAIL wrap_clear: pkt=%0d err=%0d state=%0d, expected 0/0/1", pkt_cnt, err_cnt, dbg); end
        for (int i = 0; i < 33; i++) begin
            send_beat(hdr(16'hB6CF, 5'(i)), 1'b0);
            send_beat(dat(5'(i), 8'd2, 16'hCACA), 1'b1);
            n_tests++; if (strobe !== 1'b1 || code !== 2'd0) begin n_fail++;
                $display("FAIL wrap_pkt%0d: strobe=%b code=%0d, expected 1/0", i, strobe, code); end
        end
        n_tests++; if (pkt_cnt !== 16'd33 || err_cnt !== 16'd0 || last_hdr !== 32'hB6CF_8000) begin n_fail++;
            $display("FAIL wrap_totals: pkt=%0d err=%0d hdr=%h, expected 33/0/b6cf8000", pkt_cnt, err_cnt, last_hdr); end
    endtask

    task automatic test_fa_coincident();
        tdata = hdr(16'hB6CF, 5'd1); tvalid = 1'b1; tlast = 1'b0;
        fa_pulse(5'd5);
        tvalid = 1'b0;
        n_tests++; if (strobe !== 1'b0 || dbg !== 2'd1 || pkt_cnt !== 16'd0 || last_hdr !== 32'hB6CF_8000) begin n_fail++;
            $display("FAIL fa_coinc: strobe=%b state=%0d pkt=%0d hdr=%h, expected 0/1/0/b6cf8000", strobe, dbg, pkt_cnt, last_hdr); end
        send_beat(hdr(16'hB6CF, 5'd5), 1'b0);
        send_beat(dat(5'd0, 8'd3, 16'hCACA), 1'b1);
        n_tests++; if (strobe !== 1'b1 || code !== 2'd0 || pkt_cnt !== 16'd1) begin n_fail++;
            $display("FAIL fa_coinc_next: strobe=%b code=%0d pkt=%0d, expected 1/0/1", strobe, code, pkt_cnt); end
    endtask

    task automatic test_reset_mid();
        send_beat(hdr(16'hB6CF, 5'd6), 1'b0);
        rst_n = 1'b0;
        #1;
        n_tests++; if ({tready, strobe, code, dbg} !== 6'd0 || {pkt_cnt, err_cnt, last_hdr} !== 64'd0) begin n_fail++;
            $display("FAIL async_reset: tready=%b strobe=%b code=%0d state=%0d pkt=%0d err=%0d hdr=%h, expected all 0",
                     tready, strobe, code, dbg, pkt_cnt, err_cnt, last_hdr); end
        @(negedge clk); rst_n = 1'b1;
        idle_cycle();
        fa_pulse(5'd2);
        send_beat(hdr(16'hB6CF, 5'd2), 1'b0);
        send_beat(dat(5'd0, 8'd1, 16'hCACA), 1'b1);
        n_tests++; if (strobe !== 1'b1 || code !== 2'd0 || pkt_cnt !== 16'd1 || last_hdr !== 32'hB6CF_8800) begin n_fail++;
            $display("FAIL reset_restart: strobe=%b code=%0d pkt=%0d hdr=%h, expected 1/0/1/b6cf8800", strobe, code, pkt_cnt, last_hdr); end
    endtask

    initial begin
        rst_n = 1'b0; fa = 1'b0; chan_up = 1'b0; base = 5'd0;
        tdata = 32'd0; tvalid = 1'b0; tlast = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        chan_up = 1'b1;
        test_reset();
        test_basic();
        test_bad_header();
        test_bad_data();
        test_framing();
        test_chan_drop();
        test_wrap();
        test_fa_coincident();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
